// File: rtl/addsub_seq.sv
// Slice-serial add/subtract/accumulate unit: SLICE bits per clock, WIDTH/SLICE cycles per op.
// Results and flags are registered and change only on the edge that enters DONE.
module addsub_seq #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);
    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             carry_reg;
    logic             acc_wr_reg;
    logic [KW-1:0]    k_reg;

    logic [SLICE-1:0] a_slice [N];
    logic [SLICE-1:0] b_slice [N];
    logic [SLICE:0]   slice_full;
    logic             msb_cin;
    logic             last;
    logic [WIDTH-1:0] result_next;

    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign a_slice[gi] = a_reg[gi*SLICE +: SLICE];
        assign b_slice[gi] = b_reg[gi*SLICE +: SLICE];
    end

    always_comb begin
        slice_full  = {1'b0, a_slice[k_reg]} + {1'b0, b_slice[k_reg]} + {{SLICE{1'b0}}, carry_reg};
        // Carry into the slice MSB recovered from the MSB sum bit and its two operand bits.
        msb_cin     = slice_full[SLICE-1] ^ a_slice[k_reg][SLICE-1] ^ b_slice[k_reg][SLICE-1];
        last        = (k_reg == KW'(N - 1));
        result_next = shadow_reg;
        result_next[k_reg*SLICE +: SLICE] = slice_full[SLICE-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            sum        <= '0;
            carryout   <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b1;
            acc_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            shadow_reg <= '0;
            carry_reg  <= 1'b0;
            acc_wr_reg <= 1'b0;
            k_reg      <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg      <= (op == 2'b10) ? acc_reg : a;
                        b_reg      <= (op == 2'b01) ? ~b : ((op == 2'b11) ? '0 : b);
                        carry_reg  <= (op == 2'b01);
                        acc_wr_reg <= op[1];
                        k_reg      <= '0;
                        busy       <= 1'b1;
                        state_reg  <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    shadow_reg <= result_next;
                    carry_reg  <= slice_full[SLICE];
                    k_reg      <= k_reg + KW'(1);
                    if (last) begin
                        sum       <= result_next;
                        carryout  <= slice_full[SLICE];
                        overflow  <= msb_cin ^ slice_full[SLICE];
                        zero      <= (result_next == '0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                        if (acc_wr_reg) begin
                            acc_reg <= result_next;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised, slice-serial add/subtract/accumulate unit; the sequential successor to the team's combinational 8-bit adder. It processes `SLICE` bits per clock, so wide operands cost `WIDTH/SLICE` cycles instead of one long carry chain. It produces the same sum/carry/overflow results, plus a zero flag, an internal accumulator, and a start/busy/done handshake. It sits in the ALU datapath behind the operand registers.

## Interface
- `WIDTH`, 8: operand/result width in bits; must be a multiple of `SLICE`.
- `SLICE`, 4: bits added per cycle; `N = WIDTH/SLICE` (N ≥ 1).
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  request; accepted only in IDLE or DONE.
- `op`  in  2  operation: 00 add (a+b), 01 sub (a−b), 10 acc-add (acc+b), 11 load (a+0, writes acc).
- `a`  in  WIDTH  operand A, latched at accept.
- `b`  in  WIDTH  operand B, latched at accept.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse: result outputs updated.
- `sum`  out  WIDTH  result, held until next done.
- `carryout`  out  1  carry out of MSB; for sub, 1 = no borrow.
- `overflow`  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- `zero`  out  1  `sum == 0`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE → RUN: on `start`=1. Latch `op`, A operand (`a`, or `acc` for op 10), and B operand (`b`, `~b` for sub, 0 for load). Clear slice index. Set internal carry = 1 for sub, else 0.
  - RUN: each cycle, add slice k of A and B plus the internal carry into the shadow result; store the slice carry; k increments.
  - RUN → DONE: after slice N−1 is processed. Shadow result and flags copy to outputs; `acc` updates if op is 10 or 11.
  - DONE → IDLE: next edge, unless `start`=1, which goes directly to RUN (back-to-back).
- `start` in RUN is ignored; no queueing.
- `a`, `b` and `op` changes during RUN have no effect.
- Outputs never show partial sums; `sum` and flags change only on the edge that enters DONE.
- Load (op 11): `carryout`=0, `overflow`=0, `zero` per value.
- `acc` is WIDTH bits. It is not an output; it is observable via `sum` after op 10/11.
- Arithmetic is modulo 2^WIDTH; `overflow` uses two's-complement rules for all ops.

## Timing
- Reset (`rst_n`=0 at edge) → IDLE.
  - `busy`=0, `done`=0, `sum`=0, `carryout`=0, `overflow`=0, `acc`=0.
  - `zero`=1 (follows `sum`=0).
- Reset mid-operation aborts with the same values; no `done` pulse is produced for the aborted op.
- Latency: if `start` is accepted at edge E, `busy`=1 from E through E+N. `done`=1 and results are valid for exactly one cycle, from E+N to E+N+1.
- Throughput: one op per N cycles when `start` is held high through DONE.
- N=1 (SLICE=WIDTH): RUN lasts one cycle; behaviour is otherwise identical.

## Test plan
- WIDTH=8/SLICE=4:
  - 1+2 → sum=3, c=0, v=0, z=0.
  - 127+10 → 137, c=0, v=1.
  - 250+236 (−6+−20) → 230, c=1, v=0.
  - 129+129 (−127+−127) → 2, c=1, v=1.
  - `done` exactly 2 cycles after accept.
- Sub, WIDTH=8:
  - 3−5 → 254, c=0, v=0.
  - 128−1 → 127, c=1, v=1.
  - 7−7 → 0, c=1, z=1.
- Accumulator, WIDTH=8:
  - load 100 → sum=100.
  - acc-add b=50 → sum=150, v=1.
  - acc-add b=106 → 0, c=1, z=1.
  - add 1+1 leaves acc unchanged: next acc-add b=0 → sum=0.
- Handshake:
  - Pulse `start` during RUN with different operands → ignored; exactly one `done` for the first op.
  - Hold `start` with new operands through DONE → next `done` exactly N cycles later.
- WIDTH=16/SLICE=4:
  - 0xFFFF+0x0001 → 0, c=1, v=0, z=1.
  - `done` 4 cycles after accept.
  - `sum` holds its previous value throughout RUN.
- Reset: drop `rst_n` for one edge during RUN → `busy`=0, `sum`=0, `zero`=1, no `done`; next op 10 with b=5 → sum=5.
